// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: opcodes, bubble word, fetch FSM states.
package if_stage_pkg;

  localparam logic [2:0] OP_LDD = 3'b001;
  localparam logic [2:0] OP_STD = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;

  // Bubble for the default 16-bit instruction width; width-generic blocks build it from OP_NOP.
  localparam logic [15:0] BUBBLE_INSTR = {OP_NOP, 13'b0};

  typedef enum logic {
    VEC = 1'b0,
    RUN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect/stall controls in, instruction-memory port and IF/ID contents out.
interface if_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  // if_id_valid qualifies if_id_instr/if_id_pc_plus1; stall is the consumer's not-ready and
  // holds them unchanged, so a word is handed downstream on each edge with valid high and stall low.
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc_plus1;
  logic               if_id_valid;
  logic [2:0]         opcode;

  modport master (
    input  stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, opcode
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, opcode
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load / hold / flush-to-bubble, synchronous reset to bubble.
module if_stage_if_id_reg
  import if_stage_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc_plus1,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc_plus1,
  output logic               o_valid
);

  localparam logic [INSTR_W-1:0] BUBBLE = {OP_NOP, {(INSTR_W-3){1'b0}}};

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_plus1;
  logic               r_valid;

  // Flush wins over load so a redirect never lets the wrong-path word through.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_instr    <= BUBBLE;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus1 <= i_pc_plus1;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus1 = r_pc_plus1;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM, next-PC mux and the IF/ID register.
// Define IF_RESET_VECTOR_EN to load the start PC from imem[RESET_PC] after reset.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus,
  output fetch_state_e o_dbg_state
);

`ifdef IF_RESET_VECTOR_EN
  localparam fetch_state_e RST_STATE = VEC;
`else
  localparam fetch_state_e RST_STATE = RUN;
`endif

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_vec_pc;
  logic              w_load;
  logic              w_flush;

  assign w_pc_plus1 = r_pc + ADDR_W'(1);

  // The reset-vector word is zero-extended when the address is wider than an instruction.
  generate
    if (ADDR_W > INSTR_W) begin : g_zext
      assign w_vec_pc = {{(ADDR_W-INSTR_W){1'b0}}, bus.imem_data};
    end else begin : g_trunc
      assign w_vec_pc = bus.imem_data[ADDR_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  always_comb begin
    w_next_state = RUN;
    w_next_pc    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      VEC: w_next_pc = w_vec_pc;
      RUN: begin
        if (bus.branch_taken) begin
          w_next_pc = bus.branch_target;
          w_flush   = 1'b1;
        end else if (!bus.stall) begin
          w_next_pc = w_pc_plus1;
          w_load    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  if_stage_if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (bus.imem_data),
    .i_pc_plus1 (w_pc_plus1),
    .o_instr    (bus.if_id_instr),
    .o_pc_plus1 (bus.if_id_pc_plus1),
    .o_valid    (bus.if_id_valid)
  );

  assign bus.imem_addr = r_pc;
  assign bus.opcode    = bus.if_id_instr[INSTR_W-1 -: 3];
  assign o_dbg_state   = r_state;

endmodule
